// File: rtl/alarm_event_uart_tx.sv
// Alarm event reporter: detects changes of the alarm state / fuel pump inputs,
// queues one event byte per change in a small FIFO and sends the bytes as 8N1 UART frames.
module alarm_event_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 10417,
   parameter int unsigned DEPTH        = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [2:0]               alarm_state,
   input  logic                     fuel_pump,
   input  logic                     overflow_clr,
   output logic                     tx,
   output logic                     busy,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   fifo_level
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned LW = PW + 1;
   localparam logic [CW-1:0] BaudLast = CW'(CLKS_PER_BIT - 1);
   localparam logic [LW-1:0] LevelFull = LW'(DEPTH);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   baud_q, baud_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic [7:0]      shift_q, shift_d;
   logic            tx_q, tx_d;

   logic [2:0]      prev_state_q;
   logic            prev_fuel_q;
   logic [2:0]      seq_q;
   logic [7:0]      mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]   count_q;
   logic            overflow_q;

   logic            ev, full, pop, push, drop, bit_end;
   logic [7:0]      ev_byte;

   // Event detection and FIFO push/pop qualification
   always_comb begin
      ev      = (alarm_state != prev_state_q) | (fuel_pump != prev_fuel_q);
      ev_byte = {alarm_state, fuel_pump, (alarm_state == 3'd3), seq_q};
      full    = (count_q == LevelFull);
      pop     = (state_q == StIdle) && (count_q != '0);
      // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted
      push    = ev && (!full || pop);
      drop    = ev && full && !pop;
   end

   // Input history, sequence counter, FIFO storage and sticky overflow flag
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prev_state_q <= '0;
         prev_fuel_q  <= 1'b0;
         seq_q        <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         overflow_q   <= 1'b0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         prev_state_q <= alarm_state;
         prev_fuel_q  <= fuel_pump;
         // Dropped events still consume a sequence number so the receiver sees the gap
         if (ev) begin
            seq_q <= seq_q + 3'd1;
         end
         if (push) begin
            mem_q[wr_ptr_q] <= ev_byte;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         // Set wins over clear
         if (drop) begin
            overflow_q <= 1'b1;
         end else if (overflow_clr) begin
            overflow_q <= 1'b0;
         end
      end
   end

   // Transmit FSM next-state: start bit, 8 data bits LSB first, stop bit
   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      tx_d      = tx_q;
      bit_end   = (baud_q == BaudLast);
      unique case (state_q)
         StIdle: begin
            tx_d   = 1'b1;
            baud_d = '0;
            if (pop) begin
               shift_d = mem_q[rd_ptr_q];
               tx_d    = 1'b0;
               state_d = StStart;
            end
         end
         StStart: begin
            if (bit_end) begin
               baud_d    = '0;
               bit_idx_d = '0;
               tx_d      = shift_q[0];
               state_d   = StData;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         StData: begin
            if (bit_end) begin
               baud_d = '0;
               if (bit_idx_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = StStop;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  shift_d   = {1'b0, shift_q[7:1]};
                  tx_d      = shift_q[1];
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         StStop: begin
            if (bit_end) begin
               baud_d  = '0;
               tx_d    = 1'b1;
               state_d = StIdle;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: begin
            tx_d    = 1'b1;
            state_d = StIdle;
         end
      endcase
   end

   // Transmit FSM state; tx is registered so the line never glitches
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         baud_q    <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
      end
   end

   // Output mapping
   always_comb begin
      tx         = tx_q;
      busy       = (state_q != StIdle);
      overflow   = overflow_q;
      fifo_level = count_q;
   end

endmodule
